// File: rtl/sort_chunk_phase.sv
// sort_chunk_phase: one sorting pass over len elements of the ping bank.
// Elements are read two per cycle into a CHUNK-element buffer. A partial last
// chunk is padded with a sentinel. The buffer goes to an external ascending
// sorter, and the sorted result is written back to the pong bank at the same
// base address, either ascending or in descending order.
// Ports:
//   clock, reset              - clock, synchronous active-high reset
//   start_in/len_in/desc_in   - pass request (sampled in IDLE only)
//   busy_out/done_out         - pass in progress / one-cycle completion pulse
//   ping_*                    - two-lane read port (data valid one cycle later)
//   sort_valid_out/flat_out   - chunk issue to the sorter (element 0 in LSBs)
//   sort_valid_in/flat_in     - sorted chunk back from the sorter
//   pong_*                    - two-lane write port with per-lane enables
module sort_chunk_phase #(
  parameter int unsigned ELEM_W = 128,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CHUNK  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start_in,
  input  logic [ADDR_W-1:0]       len_in,
  input  logic                    desc_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [ADDR_W-1:0]       ping_addr_out,
  output logic                    ping_read_en,
  input  logic [ELEM_W-1:0]       even_data_in,
  input  logic [ELEM_W-1:0]       odd_data_in,
  output logic                    sort_valid_out,
  output logic [CHUNK*ELEM_W-1:0] sort_flat_out,
  input  logic                    sort_valid_in,
  input  logic [CHUNK*ELEM_W-1:0] sort_flat_in,
  output logic [ADDR_W-1:0]       pong_addr_out,
  output logic [ELEM_W-1:0]       even_data_out,
  output logic [ELEM_W-1:0]       odd_data_out,
  output logic                    pong_we_even,
  output logic                    pong_we_odd
);

  localparam int unsigned BEATS  = CHUNK / 2;
  localparam int unsigned CNT_W  = $clog2(BEATS + 1);
  localparam int unsigned SLOT_W = $clog2(CHUNK);
  localparam int unsigned EXT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_WRITE, S_FIN
  } state_t;

  typedef logic [CHUNK-1:0][ELEM_W-1:0] chunk_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              desc_q, desc_d;
  chunk_t            buf_q, buf_d;

  logic              busy_d, done_d, read_en_d, sort_valid_d;
  logic [ADDR_W-1:0] ping_addr_d, pong_addr_d;
  logic [ELEM_W-1:0] even_d, odd_d;
  logic              we_even_d, we_odd_d;

  logic [SLOT_W-1:0] ld_slot, wr_slot;
  logic [EXT_W-1:0]  ld_abs, wr_abs, len_ext, base_next;
  logic [ELEM_W-1:0] sentinel;
  logic              wr_go;
  logic [CNT_W-1:0]  wr_beat;
  chunk_t            wr_src;

  // The same buffer holds the assembled chunk and, later, the sorted result.
  assign sort_flat_out = buf_q;

  // Next state, next registered outputs and buffer updates
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    len_d        = len_q;
    desc_d       = desc_q;
    buf_d        = buf_q;
    done_d       = 1'b0;
    read_en_d    = 1'b0;
    ping_addr_d  = '0;
    sort_valid_d = 1'b0;
    pong_addr_d  = '0;
    even_d       = '0;
    odd_d        = '0;
    we_even_d    = 1'b0;
    we_odd_d     = 1'b0;
    wr_go        = 1'b0;
    wr_beat      = '0;
    wr_src       = buf_q;
    wr_slot      = '0;
    wr_abs       = '0;

    // Data arriving with counter value k belongs to the read issued at k-1.
    ld_slot   = SLOT_W'({cnt_q - CNT_W'(1), 1'b0});
    len_ext   = {1'b0, len_q};
    ld_abs    = {1'b0, base_q} + EXT_W'(ld_slot);
    // One extra bit so a base that wraps at the bank end still ends the pass.
    base_next = {1'b0, base_q} + EXT_W'(CHUNK);
    // Padding sorts to the tail in either direction.
    sentinel  = {ELEM_W{~desc_q}};

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          len_d  = len_in;
          desc_d = desc_in;
          base_d = '0;
          cnt_d  = '0;
          if (len_in == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d     = S_LOAD;
            read_en_d   = 1'b1;
            ping_addr_d = '0;
          end
        end
      end

      S_LOAD: begin
        if (cnt_q != '0) begin
          buf_d[ld_slot] = (ld_abs < len_ext) ? even_data_in : sentinel;
          buf_d[ld_slot + SLOT_W'(1)] =
            ((ld_abs + EXT_W'(1)) < len_ext) ? odd_data_in : sentinel;
        end
        if (cnt_q == CNT_W'(BEATS)) begin
          state_d      = S_ISSUE;
          sort_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d != CNT_W'(BEATS)) begin
            read_en_d   = 1'b1;
            ping_addr_d = base_q + (ADDR_W'(cnt_d) << 1);
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (sort_valid_in) begin
          buf_d   = sort_flat_in;
          state_d = S_WRITE;
          cnt_d   = '0;
          // First beat is taken straight from the sorter bus.
          wr_go   = 1'b1;
          wr_beat = '0;
          wr_src  = sort_flat_in;
        end
      end

      S_WRITE: begin
        if (cnt_q != CNT_W'(BEATS - 1)) begin
          cnt_d   = cnt_q + CNT_W'(1);
          wr_go   = 1'b1;
          wr_beat = cnt_d;
        end else begin
          cnt_d  = '0;
          base_d = base_next[ADDR_W-1:0];
          if (base_next >= len_ext) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d     = S_LOAD;
            read_en_d   = 1'b1;
            ping_addr_d = base_next[ADDR_W-1:0];
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Write beat: descending order reads the sorted chunk from its top end.
    if (wr_go) begin
      wr_slot     = SLOT_W'({wr_beat, 1'b0});
      wr_abs      = {1'b0, base_q} + EXT_W'(wr_slot);
      pong_addr_d = base_q + ADDR_W'(wr_slot);
      even_d      = desc_q ? wr_src[SLOT_W'(CHUNK - 1) - wr_slot]
                           : wr_src[wr_slot];
      odd_d       = desc_q ? wr_src[SLOT_W'(CHUNK - 2) - wr_slot]
                           : wr_src[wr_slot + SLOT_W'(1)];
      we_even_d   = (wr_abs < len_ext);
      we_odd_d    = ((wr_abs + EXT_W'(1)) < len_ext);
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      base_q         <= '0;
      len_q          <= '0;
      desc_q         <= 1'b0;
      buf_q          <= '0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      ping_read_en   <= 1'b0;
      ping_addr_out  <= '0;
      sort_valid_out <= 1'b0;
      pong_addr_out  <= '0;
      even_data_out  <= '0;
      odd_data_out   <= '0;
      pong_we_even   <= 1'b0;
      pong_we_odd    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      base_q         <= base_d;
      len_q          <= len_d;
      desc_q         <= desc_d;
      buf_q          <= buf_d;
      busy_out       <= busy_d;
      done_out       <= done_d;
      ping_read_en   <= read_en_d;
      ping_addr_out  <= ping_addr_d;
      sort_valid_out <= sort_valid_d;
      pong_addr_out  <= pong_addr_d;
      even_data_out  <= even_d;
      odd_data_out   <= odd_d;
      pong_we_even   <= we_even_d;
      pong_we_odd    <= we_odd_d;
    end
  end

endmodule

// File: doc/sort_chunk_phase.md
Name: sort_chunk_phase

Overview:
- Parametrised successor to the fixed 16-entry sort pass.
- Streams a caller-specified number of elements from the ping bank two at a time, one CHUNK at a time.
- Hands each chunk to an external bitonic sorter, then writes each sorted chunk to the pong bank at the same base address.
- Adds explicit start/busy/done handshake, descending mode, sentinel padding of a partial last chunk, and per-lane write masking so padding is never written.

Parameters:
ELEM_W, 128, width of one element (tuple pair).
ADDR_W, 12, bank address width; also width of len_in.
CHUNK, 16, elements per sort chunk; power of two, 4..64.

Ports:
clock  input  1  clock.
reset  input  1  reset, synchronous, active-high.
start_in  input  1  begin a pass; sampled only in IDLE.
len_in  input  ADDR_W  element count, latched on accepted start.
desc_in  input  1  0 ascending, 1 descending; latched on accepted start.
busy_out  output  1  high from accepted start until done cycle inclusive.
done_out  output  1  one-cycle pulse when pass completes.
ping_addr_out  output  ADDR_W  even-lane read address (odd lane = +1).
ping_read_en  output  1  read strobe; data valid next cycle.
even_data_in, odd_data_in  input  ELEM_W each  ping read data.
sort_valid_out  output  1  one-cycle chunk issue to sorter.
sort_flat_out  output  CHUNK*ELEM_W  chunk to sorter, element 0 in LSBs.
sort_valid_in  input  1  sorter result valid.
sort_flat_in  input  CHUNK*ELEM_W  ascending-sorted chunk.
pong_addr_out  output  ADDR_W  even-lane write address.
even_data_out, odd_data_out  output  ELEM_W each  write data.
pong_we_even, pong_we_odd  output  1 each  per-lane write enables.

Behaviour:
- Reset: FSM to IDLE; all outputs 0; internal chunk base 0. Reset mid-pass aborts immediately; no further reads, writes, or done.
- States: IDLE, LOAD, ISSUE, WAIT, WRITE, FIN.
- IDLE: start_in=1 latches len and desc, sets base=0, busy=1.
  - len=0 goes to FIN directly: no memory access, done next cycle.
  - Otherwise goes to LOAD.
- LOAD: CHUNK/2 consecutive cycles with ping_read_en=1, ping_addr_out = base, base+2, ...
  - Data returned in cycle k+1 is stored at chunk slots 2k, 2k+1.
  - A slot whose absolute index >= len is replaced by the sentinel instead: all-ones if ascending, all-zeros if descending.
  - Reads are issued even for slots beyond len (addresses are harmless).
  - Last data beat lands one cycle after the final read; then ISSUE.
- ISSUE: sort_valid_out=1 for exactly one cycle with the assembled chunk; then WAIT.
- WAIT: holds until sort_valid_in=1, then latches sort_flat_in and goes to WRITE.
  - sort_valid_in in any other state is ignored.
  - No timeout.
- WRITE: CHUNK/2 cycles; beat j writes pong_addr_out = base+2j.
  - Ascending: lanes take sorted[2j] and sorted[2j+1].
  - Descending: lanes take sorted[CHUNK-1-2j] and sorted[CHUNK-2-2j].
  - Lane enable is 1 only if its absolute index < len, so a padded tail is never written and an odd len leaves pong_we_odd=0 on the last valid beat.
  - Beats fully beyond len have both enables 0.
- After WRITE: base += CHUNK. If base >= len go to FIN, else LOAD.
- FIN: done_out=1 for one cycle, busy_out=1 this cycle, then IDLE. A start_in in the FIN cycle is ignored.
- Only one chunk in flight. Per-chunk latency = CHUNK/2 + 1 (LOAD) + 1 (ISSUE) + sorter latency + CHUNK/2 (WRITE) cycles.
- Arithmetic:
  - Address arithmetic is ADDR_W wide. len equal to the bank size is legal; base wrap to 0 must still terminate via the comparison done in ADDR_W+1 bits.
  - Sentinel padding relies on the sorter being stable with respect to equal keys only for ordering, not identity; genuine elements equal to the sentinel may appear anywhere in the padded region without affecting correctness of the written prefix.

Test Plan:
- len=16, ascending, ping = 15..0, sorter model latency 10 → 8 write beats at addr 0,2..14 writing 0..15, both enables 1; done pulses once; busy low the next cycle.
- len=5, ascending, values {9,3,7,1,5} → one chunk; slots 5..15 padded all-ones; writes 1,3 / 5,7 / 9 with pong_we_odd=0 on beat 2; beats 3..7 have enables 0.
- len=20, descending, ping = 0..19 → chunk 0 writes 15..0 at addr 0..15; chunk 1 writes 19,18,17,16 at addr 16..19; zero padding never written.
- len=0 start → no ping_read_en, no sort_valid_out; done_out one cycle after start.
- start_in held high through a len=16 pass → second pass starts only after return to IDLE; spurious sort_valid_in during LOAD ignored.
- Reset asserted on the 3rd WRITE beat → next cycle all enables 0, busy 0, no done; a new start then runs correctly from base 0.
